// File: rtl/nn_ctrl_pkg.sv
// Shared control definitions for the NN layer scheduler and the layer sequencer.
// Holds the sequencer state encoding, geometry defaults and the layer latency formula.
package nn_ctrl_pkg;

    localparam int N_IN_MAX_DEF  = 64;
    localparam int N_OUT_MAX_DEF = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } seq_state_t;

    // Cycles from the cycle in which start is sampled to the cycle in which done is high.
    function automatic int layer_latency(input int n_in, input int n_out,
                                         input int mem_lat, input int bias);
        if (n_in == 0 || n_out == 0) return 1;
        return n_out * (n_in + bias + mem_lat + 2) + 1;
    endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Scheduler <-> layer sequencer bundle: start/done handshake, layer geometry,
// MAC control and memory read / activation write addressing.
interface layer_sequencer_if #(
    parameter int N_IN_MAX  = nn_ctrl_pkg::N_IN_MAX_DEF,
    parameter int N_OUT_MAX = nn_ctrl_pkg::N_OUT_MAX_DEF,
    parameter int WADDR_W   = 12
);
    localparam int IN_W  = $clog2(N_IN_MAX + 1);
    localparam int OUT_W = $clog2(N_OUT_MAX + 1);
    localparam int ACT_W = $clog2(N_OUT_MAX);

    logic               start;
    logic               abort;
    logic [IN_W-1:0]    n_in;
    logic [OUT_W-1:0]   n_out;
    logic [WADDR_W-1:0] w_base;
    logic               busy;
    logic               done;
    logic [IN_W-1:0]    in_addr;
    logic [WADDR_W-1:0] w_addr;
    logic               mac_clr;
    logic               mac_en;
    logic               act_we;
    logic [ACT_W-1:0]   act_addr;

    modport master (
        output start, abort, n_in, n_out, w_base,
        input  busy, done, in_addr, w_addr, mac_clr, mac_en, act_we, act_addr
    );

    modport slave (
        input  start, abort, n_in, n_out, w_base,
        output busy, done, in_addr, w_addr, mac_clr, mac_en, act_we, act_addr
    );

endinterface

// File: rtl/valid_delay.sv
// Delays a read-valid strobe by STAGES cycles to line it up with memory read data.
// flush clears every stage synchronously so no stale strobe survives an abort.
module valid_delay #(
    parameter int STAGES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic vld_in,
    output logic vld_out
);
    logic [STAGES-1:0] vld_p;
    logic [STAGES:0]   shift_in;

    assign shift_in = {vld_p, vld_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else if (flush) begin
            vld_p <= '0;
        end else begin
            vld_p <= shift_in[STAGES-1:0];
        end
    end

    assign vld_out = vld_p[STAGES-1];

endmodule

// File: rtl/layer_sequencer.sv
// Sequences one fully-connected layer on the shared MAC array, neuron by neuron.
// Define LAYER_SEQ_BIAS_EN to append a bias read (in_addr = n_in) to every neuron.
module layer_sequencer
    import nn_ctrl_pkg::*;
#(
    parameter int N_IN_MAX  = N_IN_MAX_DEF,
    parameter int N_OUT_MAX = N_OUT_MAX_DEF,
    parameter int WADDR_W   = 12,
    parameter int MEM_LAT   = 1
) (
    input logic              clk,
    input logic              rst_n,
    layer_sequencer_if.slave bus
);
    localparam int IN_W  = $clog2(N_IN_MAX + 1);
    localparam int OUT_W = $clog2(N_OUT_MAX + 1);
    localparam int ACT_W = $clog2(N_OUT_MAX);
    localparam int DRN_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
`ifdef LAYER_SEQ_BIAS_EN
    localparam logic BIAS = 1'b1;
`else
    localparam logic BIAS = 1'b0;
`endif

    seq_state_t         state, state_nxt;
    logic [IN_W-1:0]    n_in_q, in_cnt, in_addr_q, last_in;
    logic [OUT_W-1:0]   n_out_q;
    logic [ACT_W-1:0]   out_cnt;
    logic [WADDR_W-1:0] wptr, w_addr_q;
    logic [DRN_W-1:0]   drn_cnt;
    logic               accept, last_out;
    logic               rd_vld, mac_clr, act_we, done;

    assign accept   = (state == S_IDLE) && bus.start && !bus.abort;
    assign last_in  = BIAS ? n_in_q : n_in_q - IN_W'(1);
    assign last_out = (OUT_W'(out_cnt) == (n_out_q - OUT_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd_vld    = 1'b0;
        mac_clr   = 1'b0;
        act_we    = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept)
                    state_nxt = (bus.n_in == '0 || bus.n_out == '0) ? S_DONE : S_CLEAR;
            end
            S_CLEAR: begin
                mac_clr   = 1'b1;
                state_nxt = S_ACCUM;
            end
            S_ACCUM: begin
                rd_vld = 1'b1;
                if (in_cnt == last_in) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (drn_cnt == '0) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                act_we    = 1'b1;
                state_nxt = last_out ? S_DONE : S_CLEAR;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // Abort beats every transition and suppresses any write-back or completion.
        if (bus.abort) begin
            state_nxt = S_IDLE;
            act_we    = 1'b0;
            done      = 1'b0;
        end
    end

    // Running weight pointer walks w_base + out_cnt*stride + in_cnt without a multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_in_q    <= '0;
            n_out_q   <= '0;
            wptr      <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            drn_cnt   <= '0;
            in_addr_q <= '0;
            w_addr_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        n_in_q  <= bus.n_in;
                        n_out_q <= bus.n_out;
                        wptr    <= bus.w_base;
                        out_cnt <= '0;
                    end
                end
                S_CLEAR: in_cnt <= '0;
                S_ACCUM: begin
                    in_addr_q <= in_cnt;
                    w_addr_q  <= wptr;
                    in_cnt    <= in_cnt + IN_W'(1);
                    wptr      <= wptr + WADDR_W'(1);
                    drn_cnt   <= DRN_W'(MEM_LAT - 1);
                end
                S_DRAIN: drn_cnt <= drn_cnt - DRN_W'(1);
                S_WRITE: begin
                    if (!last_out) out_cnt <= out_cnt + ACT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Read strobe -> MEM_LAT pipeline -> mac_en, aligned with returning read data.
    valid_delay #(
        .STAGES (MEM_LAT)
    ) u_vld_dly (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (bus.abort),
        .vld_in  (rd_vld),
        .vld_out (bus.mac_en)
    );

    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = done;
    assign bus.mac_clr  = mac_clr;
    assign bus.act_we   = act_we;
    assign bus.act_addr = out_cnt;
    assign bus.in_addr  = (state == S_ACCUM) ? in_cnt : in_addr_q;
    assign bus.w_addr   = (state == S_ACCUM) ? wptr   : w_addr_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized bench for layer_sequencer: a behavioural MAC/memory model rebuilds each
// neuron's dot product from the bus activity and compares it against plain arithmetic.
module tb_layer_sequencer;
    import nn_ctrl_pkg::*;

    localparam int N_IN_MAX  = 64;
    localparam int N_OUT_MAX = 64;
    localparam int WADDR_W   = 12;
    localparam int MEM_LAT   = 1;
    localparam int WSPACE    = 1 << WADDR_W;
    localparam int IN_W      = $clog2(N_IN_MAX + 1);
    localparam int OUT_W     = $clog2(N_OUT_MAX + 1);
`ifdef LAYER_SEQ_BIAS_EN
    localparam int B = 1;
`else
    localparam int B = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    layer_sequencer_if #(.N_IN_MAX(N_IN_MAX), .N_OUT_MAX(N_OUT_MAX), .WADDR_W(WADDR_W)) bus_if ();

    layer_sequencer #(
        .N_IN_MAX  (N_IN_MAX),
        .N_OUT_MAX (N_OUT_MAX),
        .WADDR_W   (WADDR_W),
        .MEM_LAT   (MEM_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Memory contents and observed-activity model
    logic signed [7:0] xmem [0:N_IN_MAX];
    logic signed [7:0] wmem [0:WSPACE-1];
    int cyc = 0;
    int hist_in [16];
    int hist_w  [16];
    int acc, en_cnt, clr_cnt, en_total, done_cnt, done_cyc, noclr_err;
    bit armed;
    int wr_addr_q[$], wr_acc_q[$], wr_cnt_q[$], seq_w[$], seq_in[$];

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        int k, xi;
        @(negedge clk);
        if (rst_n) begin
            hist_in[cyc % 16] = int'(bus_if.in_addr);
            hist_w[cyc % 16]  = int'(bus_if.w_addr);
            if (bus_if.mac_clr) begin
                acc = 0; en_cnt = 0; armed = 1; clr_cnt++;
            end
            if (bus_if.mac_en) begin
                k  = (cyc - MEM_LAT) % 16;
                xi = (hist_in[k] > N_IN_MAX) ? 0 : hist_in[k];
                if (!armed) noclr_err++;
                acc = acc + int'(xmem[xi]) * int'(wmem[hist_w[k]]);
                en_cnt++; en_total++;
                seq_w.push_back(hist_w[k]);
                seq_in.push_back(hist_in[k]);
            end
            if (bus_if.act_we) begin
                wr_addr_q.push_back(int'(bus_if.act_addr));
                wr_acc_q.push_back(acc);
                wr_cnt_q.push_back(en_cnt);
                armed = 0;
            end
            if (bus_if.done) begin
                if (done_cnt == 0) done_cyc = cyc;
                done_cnt++;
            end
        end
    end

    task automatic reset_mon();
        acc = 0; en_cnt = 0; clr_cnt = 0; en_total = 0; done_cnt = 0; done_cyc = -1;
        noclr_err = 0; armed = 0;
        wr_addr_q.delete(); wr_acc_q.delete(); wr_cnt_q.delete();
        seq_w.delete(); seq_in.delete();
    endtask

    task automatic fill_mem();
        for (int i = 0; i <= N_IN_MAX; i++) xmem[i] = 8'($urandom);
        for (int j = 0; j < WSPACE; j++) wmem[j] = 8'($urandom);
    endtask

    function automatic int ref_dot(input int ni, input int wb, input int o);
        int s, stride;
        s = 0;
        stride = ni + B;
        for (int i = 0; i < stride; i++)
            s += int'(xmem[i]) * int'(wmem[(wb + o * stride + i) % WSPACE]);
        return s;
    endfunction

    task automatic drive_start(input int ni, input int no, input int wb);
        bus_if.n_in   = IN_W'(ni);
        bus_if.n_out  = OUT_W'(no);
        bus_if.w_base = WADDR_W'(wb);
        bus_if.start  = 1'b1;
    endtask

    task automatic check_results(input int ni, input int wb, input int n_exp);
        int n;
        check("wr_count", wr_addr_q.size(), n_exp);
        n = (wr_addr_q.size() < n_exp) ? wr_addr_q.size() : n_exp;
        for (int o = 0; o < n; o++) begin
            check("act_addr", wr_addr_q[o], o);
            check("mac_sum", wr_acc_q[o], ref_dot(ni, wb, o));
            check("en_per_neuron", wr_cnt_q[o], ni + B);
        end
    endtask

    task automatic run_layer(input int ni, input int no, input int wb, input bit poke);
        int lat_exp, c0, waited, stride, nval, bias_seen;
        stride  = ni + B;
        nval    = (ni > 0 && no > 0) ? 1 : 0;
        lat_exp = nval ? no * (stride + MEM_LAT + 2) + 1 : 1;
        check("lat_fn", layer_latency(ni, no, MEM_LAT, B), lat_exp);
        fill_mem();
        reset_mon();
        drive_start(ni, no, wb);
        c0 = cyc;
        @(posedge clk); #1;
        waited = 0;
        while (done_cnt == 0 && waited < lat_exp + 50) begin
            if (poke && waited == 0) begin
                bus_if.start  = 1'b1;
                bus_if.n_in   = IN_W'($urandom);
                bus_if.n_out  = OUT_W'($urandom);
                bus_if.w_base = WADDR_W'($urandom);
            end else begin
                bus_if.start = 1'b0;
            end
            @(posedge clk); #1;
            waited++;
        end
        bus_if.start = 1'b0;
        check("done_seen", done_cnt > 0, 1);
        repeat (5) @(posedge clk);
        #1;
        check("single_done", done_cnt, 1);
        check("latency", done_cyc - c0, lat_exp);
        check("busy_after", bus_if.busy, 0);
        check("noclr", noclr_err, 0);
        check("clr_count", clr_cnt, nval ? no : 0);
        check("en_count", en_total, nval ? no * stride : 0);
        check_results(ni, wb, nval ? no : 0);
        if (nval) begin
            bias_seen = 0;
            for (int j = 0; j < seq_w.size(); j++) begin
                check("w_seq", seq_w[j], (wb + j) % WSPACE);
                check("in_seq", seq_in[j], j % stride);
                if (seq_in[j] == ni) bias_seen++;
            end
            check("bias_slots", bias_seen, B ? no : 0);
            check("w_hold", bus_if.w_addr, (wb + no * stride - 1) % WSPACE);
            check("in_hold", bus_if.in_addr, stride - 1);
        end
    endtask

    task automatic abort_test();
        int waited;
        fill_mem();
        reset_mon();
        drive_start(12, 64, 100);
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        waited = 0;
        while (!(wr_addr_q.size() == 5 && clr_cnt == 6) && waited < 500) begin
            @(posedge clk); #1;
            waited++;
        end
        check("abort_reach", waited < 500, 1);
        repeat (3) @(posedge clk);
        #1;
        bus_if.abort = 1'b1;
        @(posedge clk); #1;
        bus_if.abort = 1'b0;
        check("abort_busy", bus_if.busy, 0);
        check("abort_mac_en", bus_if.mac_en, 0);
        repeat (30) @(posedge clk);
        #1;
        check("abort_no_we", wr_addr_q.size(), 5);
        check("abort_no_done", done_cnt, 0);
        check_results(12, 100, 5);
        run_layer(5, 3, 50, 0);
    endtask

    task automatic start_abort_same_cycle();
        reset_mon();
        drive_start(3, 2, 0);
        bus_if.abort = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;
        check("sa_busy", bus_if.busy, 0);
        repeat (12) @(posedge clk);
        #1;
        check("sa_no_clr", clr_cnt, 0);
        check("sa_no_done", done_cnt, 0);
    endtask

    task automatic async_reset_test();
        reset_mon();
        drive_start(8, 8, 0);
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_busy", bus_if.busy, 0);
        check("ar_mac_en", bus_if.mac_en, 0);
        check("ar_mac_clr", bus_if.mac_clr, 0);
        check("ar_act_we", bus_if.act_we, 0);
        check("ar_done", bus_if.done, 0);
        check("ar_in_addr", bus_if.in_addr, 0);
        check("ar_w_addr", bus_if.w_addr, 0);
        check("ar_act_addr", bus_if.act_addr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("ar_no_done", done_cnt, 0);
        check("ar_idle", bus_if.busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus_if.start  = 1'b0;
        bus_if.abort  = 1'b0;
        bus_if.n_in   = '0;
        bus_if.n_out  = '0;
        bus_if.w_base = '0;
        reset_mon();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus_if.busy, 0);
        check("rst_done", bus_if.done, 0);
        check("rst_mac_clr", bus_if.mac_clr, 0);
        check("rst_mac_en", bus_if.mac_en, 0);
        check("rst_act_we", bus_if.act_we, 0);
        check("rst_in_addr", bus_if.in_addr, 0);
        check("rst_w_addr", bus_if.w_addr, 0);
        check("rst_act_addr", bus_if.act_addr, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_layer(12, 64, 0, 0);
        run_layer(64, 4, 768, 0);
        run_layer(4, 2, 4090, 0);
        run_layer(0, 5, 10, 1);
        run_layer(7, 0, 10, 1);
        run_layer(9, 3, 200, 1);
        start_abort_same_cycle();
        abort_test();
        async_reset_test();
        for (int r = 0; r < 6; r++)
            run_layer(int'($urandom_range(1, 20)), int'($urandom_range(1, 6)),
                      int'($urandom_range(0, WSPACE - 1)), 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
